// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the fetch unit and the opcode decoder.
//   - opcode field values (instr[31:26]) of the supported instruction set
//   - fetch FSM state encoding (2 bits)
//   - opcode_of(): extracts the opcode field from an instruction word
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [1:0] {
        S_REQ   = 2'b00,
        S_WAIT  = 2'b01,
        S_ISSUE = 2'b10,
        S_HALT  = 2'b11
    } fetch_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory read port, decoder handshake and
// branch/jump feedback of the fetch unit, bundled as one interface.
//   imem_rd_en/imem_addr -> memory, imem_rdata <- memory (one cycle later)
//   instr/opcode/pc/instr_valid -> decoder/datapath, instr_ready <- datapath
//   branch/jump/alu_zero <- decoder/ALU, halted -> system
// Modports:
//   master : fetch unit side
//   slave  : memory/decoder/datapath side
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic              instr_valid;
    logic              instr_ready;
    logic              branch;
    logic              jump;
    logic              alu_zero;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    modport master (
        output imem_rd_en, imem_addr, instr, opcode, instr_valid, pc, halted,
        input  imem_rdata, instr_ready, branch, jump, alu_zero
    );

    modport slave (
        input  imem_rd_en, imem_addr, instr, opcode, instr_valid, pc, halted,
        output imem_rdata, instr_ready, branch, jump, alu_zero
    );
endinterface

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selection.
//   pc       in  ADDR_W  address of the current instruction
//   instr    in  32      current instruction word
//   branch   in  1       beq taken candidate
//   jump     in  1       j instruction (priority over branch)
//   alu_zero in  1       ALU zero flag qualifying branch
//   next_pc  out ADDR_W  pc4, branch target or jump target (modulo 2^ADDR_W)
module next_pc_calc #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       instr,
    input  logic              branch,
    input  logic              jump,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_target;
    logic [5:0]        unused_opcode;

    assign unused_opcode = instr[31:26];

    assign pc4           = pc + ADDR_W'(4);
    // Jump keeps the region bits of pc4 above the 28-bit word-index field.
    assign jump_target   = {pc4[ADDR_W-1:28], instr[25:0], 2'b00};
    assign branch_target = pc4 + {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && alu_zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch FSM and PC register.
//   clk  in  1   rising-edge clock
//   rst  in  1   synchronous active-high reset
//   bus  master modport of instr_fetch_unit_if (memory port, decoder
//        handshake, branch/jump/alu_zero feedback, halted)
// Parameters: ADDR_W (pc width), RESET_PC (first fetch address, word aligned).
// Optional feature: FETCH_HALT_EN - a fetched OP_HALT word parks the FSM in
// S_HALT with halted=1; without it OP_HALT is issued like any other word.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;
    logic              instr_valid_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] next_pc;
`ifdef FETCH_HALT_EN
    logic              halted_q;
`endif

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc       (pc_q),
        .instr    (instr_q),
        .branch   (bus.branch),
        .jump     (bus.jump),
        .alu_zero (bus.alu_zero),
        .next_pc  (next_pc)
    );

    // imem_rd_en is a registered strobe: it is raised on the edge that enters
    // a request (accept, or the first S_REQ cycle after reset) and dropped on
    // the edge that leaves S_REQ, so each fetch produces exactly one pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            rd_en_q       <= 1'b0;
`ifdef FETCH_HALT_EN
            halted_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_REQ: begin
                    if (rd_en_q) begin
                        rd_en_q <= 1'b0;
                        state   <= S_WAIT;
                    end else begin
                        rd_en_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    instr_q <= bus.imem_rdata;
`ifdef FETCH_HALT_EN
                    if (opcode_of(bus.imem_rdata) == OP_HALT) begin
                        halted_q <= 1'b1;
                        state    <= S_HALT;
                    end else
`endif
                    begin
                        instr_valid_q <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_valid_q && bus.instr_ready) begin
                        pc_q          <= next_pc;
                        instr_valid_q <= 1'b0;
                        rd_en_q       <= 1'b1;
                        state         <= S_REQ;
                    end
                end
`ifdef FETCH_HALT_EN
                S_HALT: begin
                    state <= S_HALT;
                end
`endif
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    assign bus.imem_rd_en  = rd_en_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = opcode_of(instr_q);
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
`ifdef FETCH_HALT_EN
    assign bus.halted      = halted_q;
`else
    assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: bench for instr_fetch_unit.
// Two instances: dut0 (RESET_PC=0) and dutw (RESET_PC=0xFFFF_FFFC), each
// with its own memory image and decoder-side inputs.
// Honours FETCH_HALT_EN to select the expected OP_HALT behaviour.
module tb_instr_fetch_unit;

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst = 2'b11;
    logic [1:0] rdy = '0;
    logic [1:0] br  = '0;
    logic [1:0] jp  = '0;
    logic [1:0] zr  = '0;

    instr_fetch_unit_if #(.ADDR_W(32)) bus0 ();
    instr_fetch_unit_if #(.ADDR_W(32)) busw ();

    assign bus0.instr_ready = rdy[0];
    assign bus0.branch      = br[0];
    assign bus0.jump        = jp[0];
    assign bus0.alu_zero    = zr[0];
    assign busw.instr_ready = rdy[1];
    assign busw.branch      = br[1];
    assign busw.jump        = jp[1];
    assign busw.alu_zero    = zr[1];

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut0 (
        .clk (clk), .rst (rst[0]), .bus (bus0)
    );
    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dutw (
        .clk (clk), .rst (rst[1]), .bus (busw)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [logic [32:0]];

    function automatic logic [31:0] memrd(input logic d, input logic [31:0] a);
        logic [31:0] w;
        if (mem.exists({d, a})) return mem[{d, a}];
        w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    // Read data arrives one cycle after the strobe; otherwise the bus carries noise.
    always @(posedge clk) begin
        bus0.imem_rdata <= bus0.imem_rd_en ? memrd(1'b0, bus0.imem_addr) : $urandom;
        busw.imem_rdata <= busw.imem_rd_en ? memrd(1'b1, busw.imem_addr) : $urandom;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                             input logic b, input logic j, input logic z);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
        if (b && z) begin
            off = int'($signed(w[15:0]));
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [5:0]  opcode;
        logic        valid;
        logic [31:0] pc;
        logic        halted;
    } outs_t;

    function automatic outs_t get(input int d);
        outs_t o;
        if (d == 0) begin
            o.rd = bus0.imem_rd_en; o.addr = bus0.imem_addr; o.instr = bus0.instr;
            o.opcode = bus0.opcode; o.valid = bus0.instr_valid; o.pc = bus0.pc;
            o.halted = bus0.halted;
        end else begin
            o.rd = busw.imem_rd_en; o.addr = busw.imem_addr; o.instr = busw.instr;
            o.opcode = busw.opcode; o.valid = busw.instr_valid; o.pc = busw.pc;
            o.halted = busw.halted;
        end
        return o;
    endfunction

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [1:0]  e_acc, e_b, e_j, e_z, e_rst;
    logic [31:0] m_pc   [2];
    logic [31:0] m_word [2];
    int          m_rdcyc[2];
    int          m_last [2];
    bit          m_halt [2];
    outs_t       m_prev [2];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, a, e);
        end
    endtask

    task automatic monitor(input int d);
        outs_t o;
        o = get(d);
        if (e_rst[d]) begin
            chk($sformatf("rst_valid%0d", d), 32'(o.valid), 32'd0);
            chk($sformatf("rst_rd%0d", d), 32'(o.rd), 32'd0);
            chk($sformatf("rst_halted%0d", d), 32'(o.halted), 32'd0);
            chk($sformatf("rst_pc%0d", d), o.pc, (d == 1) ? 32'hFFFF_FFFC : 32'h0);
            chk($sformatf("rst_instr%0d", d), o.instr, 32'h0);
            m_pc[d]    = (d == 1) ? 32'hFFFF_FFFC : 32'h0;
            m_rdcyc[d] = -100;
            m_halt[d]  = 1'b0;
            m_last[d]  = cyc;
        end else begin
            if (e_acc[d]) begin
                m_pc[d] = ref_next(m_pc[d], m_word[d], e_b[d], e_j[d], e_z[d]);
                chk($sformatf("req_after_accept%0d", d), 32'(o.rd), 32'd1);
                chk($sformatf("valid_drop%0d", d), 32'(o.valid), 32'd0);
            end else if (m_prev[d].valid) begin
                chk($sformatf("valid_hold%0d", d), 32'(o.valid), 32'd1);
                chk($sformatf("instr_hold%0d", d), o.instr, m_prev[d].instr);
                chk($sformatf("pc_hold%0d", d), o.pc, m_prev[d].pc);
                chk($sformatf("no_req_hold%0d", d), 32'(o.rd), 32'd0);
            end
            if (o.rd) begin
                chk($sformatf("fetch_addr%0d", d), o.addr, m_pc[d]);
                chk($sformatf("rd_pulse%0d", d), 32'(m_prev[d].rd), 32'd0);
                m_rdcyc[d] = cyc;
                m_word[d]  = memrd(d[0], m_pc[d]);
                m_last[d]  = cyc;
            end
            if (cyc == m_rdcyc[d] + 2) begin
                if (HALT_EN && m_word[d][31:26] == 6'h3F) begin
                    m_halt[d] = 1'b1;
                end else begin
                    chk($sformatf("issue_lat%0d", d), 32'(o.valid), 32'd1);
                    chk($sformatf("issue_instr%0d", d), o.instr, m_word[d]);
                    chk($sformatf("issue_opcode%0d", d), 32'(o.opcode), 32'(m_word[d][31:26]));
                    chk($sformatf("issue_pc%0d", d), o.pc, m_pc[d]);
                end
            end else if (o.valid && !m_prev[d].valid) begin
                chk($sformatf("issue_early%0d", d), 32'(cyc - m_rdcyc[d]), 32'd2);
            end
            chk($sformatf("halted%0d", d), 32'(o.halted), 32'(m_halt[d]));
            if (m_halt[d]) begin
                chk($sformatf("halt_no_rd%0d", d), 32'(o.rd), 32'd0);
                chk($sformatf("halt_no_valid%0d", d), 32'(o.valid), 32'd0);
            end
            if (o.valid) begin
                m_last[d] = cyc;
            end else if (!m_halt[d] && (cyc - m_last[d]) > 4) begin
                tests++;
                fails++;
                $display("FAIL stall%0d @cyc %0d: no fetch activity for %0d cycles, required <= 4",
                         d, cyc, cyc - m_last[d]);
                m_last[d] = cyc;
            end
        end
        m_prev[d] = o;
    endtask

    task automatic tick();
        outs_t o;
        for (int d = 0; d < 2; d++) begin
            o        = get(d);
            e_acc[d] = o.valid && rdy[d];
            e_b[d]   = br[d];
            e_j[d]   = jp[d];
            e_z[d]   = zr[d];
            e_rst[d] = rst[d];
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) monitor(d);
    endtask

    task automatic wait_valid(input int d, input int lim);
        outs_t o;
        int    n;
        n = 0;
        o = get(d);
        while (!o.valid && n < lim) begin
            rdy[d] = 1'b1;
            br[d]  = 1'($urandom);
            jp[d]  = 1'($urandom);
            zr[d]  = 1'($urandom);
            tick();
            n++;
            o = get(d);
        end
        rdy[d] = 1'b0;
        if (!o.valid) begin
            tests++;
            fails++;
            $display("FAIL wait_valid%0d: instr_valid=0 after %0d cycles, required 1", d, lim);
        end
    endtask

    task automatic wait_rd(input int d, input int lim);
        outs_t o;
        int    n;
        n = 0;
        o = get(d);
        while (!o.rd && n < lim) begin
            tick();
            n++;
            o = get(d);
        end
        if (!o.rd) begin
            tests++;
            fails++;
            $display("FAIL wait_rd%0d: imem_rd_en=0 after %0d cycles, required 1", d, lim);
        end
    endtask

    task automatic accept(input int d, input logic b, input logic j, input logic z);
        rdy[d] = 1'b1; br[d] = b; jp[d] = j; zr[d] = z;
        tick();
        rdy[d] = 1'b0;
        br[d]  = 1'($urandom); jp[d] = 1'($urandom); zr[d] = 1'($urandom);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          d;
        logic [31:0] pc;
        logic [31:0] word;
        logic        b, j, z;
        int          hold;
        logic [31:0] nxt;
    } vec_t;

    vec_t tbl [14];

    task automatic run_entry(input vec_t v);
        outs_t o;
        int    d;
        d = int'(v.d);
        wait_valid(d, 12);
        o = get(d);
        chk("vec_pc", o.pc, v.pc);
        chk("vec_instr", o.instr, v.word);
        rdy[d] = 1'b0;
        for (int k = 0; k < v.hold; k++) tick();
        accept(d, v.b, v.j, v.z);
        o = get(d);
        chk("vec_req", 32'(o.rd), 32'd1);
        chk("vec_next", o.addr, v.nxt);
    endtask

    initial begin
        outs_t o;
        int    cnt_rd, cnt_valid;

        tbl[0]  = '{1'b0, 32'h0000_0000, 32'h2408_0005, 1'b0, 1'b0, 1'b0, 5, 32'h0000_0004};
        tbl[1]  = '{1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0008};
        tbl[2]  = '{1'b0, 32'h0000_0008, 32'h1000_0001, 1'b1, 1'b0, 1'b1, 0, 32'h0000_0010};
        tbl[3]  = '{1'b0, 32'h0000_0010, 32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 1, 32'h0000_000C};
        tbl[4]  = '{1'b0, 32'h0000_000C, 32'h8C01_0000, 1'b0, 1'b0, 1'b0, 2, 32'h0000_0010};
        tbl[5]  = '{1'b0, 32'h0000_0010, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 0, 32'h0000_0014};
        tbl[6]  = '{1'b0, 32'h0000_0014, 32'h0800_0040, 1'b1, 1'b1, 1'b1, 1, 32'h0000_0100};
        tbl[7]  = '{1'b0, 32'h0000_0100, 32'h1000_8000, 1'b1, 1'b0, 1'b1, 0, 32'hFFFE_0104};
        tbl[8]  = '{1'b0, 32'hFFFE_0104, 32'h0800_0010, 1'b0, 1'b1, 1'b0, 2, 32'hF000_0040};
        tbl[9]  = '{1'b0, 32'hF000_0040, 32'h3421_0001, 1'b0, 1'b0, 1'b0, 0, 32'hF000_0044};
        tbl[10] = '{1'b0, 32'hF000_0044, 32'h1000_0003, 1'b0, 1'b0, 1'b1, 0, 32'hF000_0048};
        tbl[11] = '{1'b1, 32'hFFFF_FFFC, 32'h2408_0001, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0000};
        tbl[12] = '{1'b1, 32'h0000_0000, 32'h1000_FFF7, 1'b1, 1'b0, 1'b1, 0, 32'hFFFF_FFE0};
        tbl[13] = '{1'b1, 32'hFFFF_FFE0, 32'h0800_0040, 1'b1, 1'b1, 1'b1, 0, 32'hF000_0100};
        foreach (tbl[i]) mem[{1'(tbl[i].d), tbl[i].pc}] = tbl[i].word;

        for (int d = 0; d < 2; d++) begin
            m_pc[d] = '0; m_word[d] = '0; m_rdcyc[d] = -100;
            m_last[d] = 0; m_halt[d] = 1'b0; m_prev[d] = '0;
        end

        rst = 2'b11;
        tick();
        tick();
        rst = 2'b00;

        foreach (tbl[i]) run_entry(tbl[i]);

        // Reset while dutw waits for read data; the late word must be dropped.
        wait_rd(1, 10);
        tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        o = get(1);
        chk("mid_rst_valid", 32'(o.valid), 32'd0);
        chk("mid_rst_pc", o.pc, 32'hFFFF_FFFC);
        tick();
        o = get(1);
        chk("stale_rdata_ignored", 32'(o.valid), 32'd0);
        wait_rd(1, 10);
        o = get(1);
        chk("mid_rst_refetch", o.addr, 32'hFFFF_FFFC);
        wait_valid(1, 10);
        o = get(1);
        chk("mid_rst_instr", o.instr, 32'h2408_0001);

        // Randomized traffic on dut0, checked by the monitor's model.
        for (int i = 0; i < 150; i++) begin
            wait_valid(0, 12);
            rdy[0] = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            accept(0, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
        end

        // Reset while an instruction is being offered.
        wait_valid(0, 12);
        rst[0] = 1'b1;
        tick();
        o = get(0);
        chk("issue_rst_valid", 32'(o.valid), 32'd0);
        tick();
        rst[0] = 1'b0;

        // OP_HALT word at the jump target of the word at 0.
        mem[{1'b0, 32'h0020_0014}] = 32'hFC00_0000;
        wait_valid(0, 12);
        o = get(0);
        chk("halt_pre_pc", o.pc, 32'h0);
        accept(0, 1'b0, 1'b1, 1'b0);
        o = get(0);
        chk("halt_req_addr", o.addr, 32'h0020_0014);
`ifdef FETCH_HALT_EN
        rdy[0] = 1'b1;
        tick();
        tick();
        o = get(0);
        chk("halt_set", 32'(o.halted), 32'd1);
        chk("halt_valid", 32'(o.valid), 32'd0);
        cnt_rd = 0;
        cnt_valid = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            o = get(0);
            cnt_rd += int'(o.rd);
            cnt_valid += int'(o.valid);
        end
        chk("halt_rd_count", 32'(cnt_rd), 32'd0);
        chk("halt_valid_count", 32'(cnt_valid), 32'd0);
        chk("halt_sticky", 32'(o.halted), 32'd1);
        rdy[0] = 1'b0;
`else
        cnt_rd = 0;
        cnt_valid = 0;
        wait_valid(0, 12);
        o = get(0);
        chk("halt_issued_opcode", 32'(o.opcode), 32'h3F);
        chk("halt_issued_instr", o.instr, 32'hFC00_0000);
        chk("halt_not_halted", 32'(o.halted), 32'd0);
        accept(0, 1'b0, 1'b0, 1'b0);
        o = get(0);
        chk("halt_next_addr", o.addr, 32'h0020_0018);
`endif
        rst[0] = 1'b1;
        tick();
        tick();
        rst[0] = 1'b0;
        tick();
        o = get(0);
        chk("final_halted_clear", 32'(o.halted), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
